// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one single-ported memory between instruction fetch and data access.
// Data has priority, and a starvation counter guarantees that fetch still makes forward progress.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [15:0] if_req_addr,
    output logic        if_resp_valid,
    output logic [63:0] if_resp_data,
    input  logic        dm_req_valid,
    output logic        dm_req_ready,
    input  logic [15:0] dm_req_addr,
    input  logic [7:0]  dm_req_wmask,
    input  logic [63:0] dm_req_wdata,
    output logic        dm_resp_valid,
    output logic [63:0] dm_resp_data,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [15:0] mem_req_addr,
    output logic [7:0]  mem_req_wmask,
    output logic [63:0] mem_req_wdata,
    input  logic        mem_resp_valid,
    input  logic [63:0] mem_resp_data,
    output logic        busy
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    typedef enum logic {OWN_IF, OWN_DM} owner_t;

    state_t      state;
    owner_t      owner;
    logic [3:0]  starve_cnt;
    logic        idle_ok;
    logic        grant_if;
    logic        grant_dm;
    logic        resp_hit;

    // Fetch wins a collision only once data has taken LIMIT grants in a row while it waited.
    assign idle_ok  = (state == IDLE) && !rst;
    assign grant_if = idle_ok && if_req_valid && (!dm_req_valid || starve_cnt == LIMIT);
    assign grant_dm = idle_ok && dm_req_valid && !(if_req_valid && starve_cnt == LIMIT);

    // NOTE: ready is a combinational function of the request inputs so acceptance
    // happens in the same cycle; every other output comes from registers or passes straight through.
    assign if_req_ready = grant_if;
    assign dm_req_ready = grant_dm;

    assign mem_req_valid = (state == ISSUE);
    assign busy          = (state != IDLE);

    assign resp_hit      = (state == WAIT) && mem_resp_valid && !rst;
    assign if_resp_valid = resp_hit && (owner == OWN_IF);
    assign dm_resp_valid = resp_hit && (owner == OWN_DM);
    assign if_resp_data  = if_resp_valid ? mem_resp_data : 64'd0;
    assign dm_resp_data  = dm_resp_valid ? mem_resp_data : 64'd0;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            owner         <= OWN_IF;
            starve_cnt    <= 4'd0;
            mem_req_addr  <= 16'd0;
            mem_req_wmask <= 8'd0;
            mem_req_wdata <= 64'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_if) begin
                        owner         <= OWN_IF;
                        mem_req_addr  <= if_req_addr;
                        mem_req_wmask <= 8'd0;
                        mem_req_wdata <= 64'd0;
                        starve_cnt    <= 4'd0;
                        state         <= ISSUE;
                    end else if (grant_dm) begin
                        owner         <= OWN_DM;
                        mem_req_addr  <= dm_req_addr;
                        mem_req_wmask <= dm_req_wmask;
                        mem_req_wdata <= dm_req_wdata;
                        if (if_req_valid && starve_cnt < LIMIT)
                            starve_cnt <= starve_cnt + 4'd1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: if (mem_req_ready) state <= WAIT;
                WAIT:  if (mem_resp_valid) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: reset, single fetch, collisions, starvation,
// backpressure, reset during WAIT and stray responses.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_valid, if_req_ready, if_resp_valid;
    logic [15:0] if_req_addr;
    logic [63:0] if_resp_data;
    logic        dm_req_valid, dm_req_ready, dm_resp_valid;
    logic [15:0] dm_req_addr;
    logic [7:0]  dm_req_wmask;
    logic [63:0] dm_req_wdata, dm_resp_data;
    logic        mem_req_valid, mem_req_ready, mem_resp_valid, busy;
    logic [15:0] mem_req_addr;
    logic [7:0]  mem_req_wmask;
    logic [63:0] mem_req_wdata, mem_resp_data;

    int compared   = 0;
    int mismatched = 0;

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
        .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
        .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready), .dm_req_addr(dm_req_addr),
        .dm_req_wmask(dm_req_wmask), .dm_req_wdata(dm_req_wdata),
        .dm_resp_valid(dm_resp_valid), .dm_resp_data(dm_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_wmask(mem_req_wmask), .mem_req_wdata(mem_req_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // From ISSUE: memory takes the request at once and answers one cycle later.
    task automatic serve(input string tag, input logic to_dm, input logic [63:0] data);
        check({tag, "_issue"}, mem_req_valid, 1'b1);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = data;
        #1;
        check({tag, "_if_resp_valid"}, if_resp_valid, !to_dm);
        check({tag, "_dm_resp_valid"}, dm_resp_valid, to_dm);
        check({tag, "_resp_data"}, to_dm ? dm_resp_data : if_resp_data, data);
        check({tag, "_other_data"}, to_dm ? if_resp_data : dm_resp_data, 64'd0);
        step();
        mem_resp_valid = 1'b0;
        mem_resp_data  = 64'd0;
        #1;
        check({tag, "_idle"}, busy, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        if_req_valid = 1'b0; if_req_addr = '0;
        dm_req_valid = 1'b0; dm_req_addr = '0; dm_req_wmask = '0; dm_req_wdata = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;

        // Reset: a request during reset is not accepted.
        step();
        if_req_valid = 1'b1;
        #1;
        check("rst_if_ready", if_req_ready, 1'b0);
        step();
        rst = 1'b0;
        if_req_valid = 1'b0;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_mem_valid", mem_req_valid, 1'b0);
        check("rst_mem_addr", mem_req_addr, 16'h0);
        check("rst_if_resp", if_resp_valid, 1'b0);
        check("rst_dm_resp", dm_resp_valid, 1'b0);

        // Single fetch read.
        if_req_valid = 1'b1; if_req_addr = 16'h0010;
        #1;
        check("if1_ready", if_req_ready, 1'b1);
        check("if1_dm_ready", dm_req_ready, 1'b0);
        step();
        if_req_valid = 1'b0;
        check("if1_addr", mem_req_addr, 16'h0010);
        check("if1_wmask", mem_req_wmask, 8'h00);
        check("if1_busy", busy, 1'b1);
        check("if1_ready_issue", if_req_ready, 1'b0);
        serve("if1", 1'b0, 64'h0000_0013_0000_0093);

        // Stray response while idle is ignored.
        mem_resp_valid = 1'b1; mem_resp_data = 64'h1111_2222_3333_4444;
        #1;
        check("stray_if_resp", if_resp_valid, 1'b0);
        check("stray_dm_resp", dm_resp_valid, 1'b0);
        step();
        mem_resp_valid = 1'b0;
        check("stray_busy", busy, 1'b0);
        check("stray_mem_valid", mem_req_valid, 1'b0);

        // Collision: data wins first, fetch next.
        if_req_valid = 1'b1; if_req_addr = 16'h0020;
        dm_req_valid = 1'b1; dm_req_addr = 16'h8000;
        dm_req_wmask = 8'hFF; dm_req_wdata = 64'hDEAD_BEEF_CAFE_F00D;
        #1;
        check("col_dm_ready", dm_req_ready, 1'b1);
        check("col_if_ready", if_req_ready, 1'b0);
        step();
        dm_req_valid = 1'b0;
        check("col_dm_addr", mem_req_addr, 16'h8000);
        check("col_dm_wmask", mem_req_wmask, 8'hFF);
        check("col_dm_wdata", mem_req_wdata, 64'hDEAD_BEEF_CAFE_F00D);
        serve("col_dm", 1'b1, 64'h0);
        check("col_if_ready2", if_req_ready, 1'b1);
        step();
        if_req_valid = 1'b0;
        check("col_if_addr", mem_req_addr, 16'h0020);
        check("col_if_wmask", mem_req_wmask, 8'h00);
        serve("col_if", 1'b0, 64'h0000_0000_0000_0517);

        // Starvation: both valid continuously; four data grants, then fetch.
        if_req_valid = 1'b1; if_req_addr = 16'h0040;
        dm_req_valid = 1'b1; dm_req_addr = 16'h9000; dm_req_wmask = 8'h00;
        for (int g = 0; g < 4; g++) begin
            #1;
            check("stv_dm_ready", dm_req_ready, 1'b1);
            check("stv_if_ready", if_req_ready, 1'b0);
            step();
            serve("stv_dm", 1'b1, 64'(g + 100));
        end
        #1;
        check("stv_if_wins", if_req_ready, 1'b1);
        check("stv_dm_loses", dm_req_ready, 1'b0);
        step();
        check("stv_if_addr", mem_req_addr, 16'h0040);
        serve("stv_if", 1'b0, 64'h0000_0000_0000_0013);
        // Counter cleared: data wins the next collision.
        check("stv_dm_again", dm_req_ready, 1'b1);
        check("stv_if_waits", if_req_ready, 1'b0);
        step();
        if_req_valid = 1'b0;
        dm_req_valid = 1'b0;
        serve("stv_dm_last", 1'b1, 64'h5);

        // Memory backpressure: five cycles without mem_req_ready.
        dm_req_valid = 1'b1; dm_req_addr = 16'h1238; dm_req_wmask = 8'h0F;
        dm_req_wdata = 64'h0123_4567_89AB_CDEF;
        step();
        if_req_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            mem_resp_valid = (c == 2);
            #1;
            check("bp_valid", mem_req_valid, 1'b1);
            check("bp_addr", mem_req_addr, 16'h1238);
            check("bp_wmask", mem_req_wmask, 8'h0F);
            check("bp_wdata", mem_req_wdata, 64'h0123_4567_89AB_CDEF);
            check("bp_if_ready", if_req_ready, 1'b0);
            check("bp_dm_ready", dm_req_ready, 1'b0);
            check("bp_busy", busy, 1'b1);
            check("bp_no_resp", dm_resp_valid, 1'b0);
            step();
        end
        mem_resp_valid = 1'b0;
        if_req_valid = 1'b0;
        dm_req_valid = 1'b0;
        serve("bp", 1'b1, 64'hAAAA_5555_AAAA_5555);

        // Reset while waiting for a response: the late response is dropped.
        dm_req_valid = 1'b1; dm_req_addr = 16'h2000; dm_req_wmask = 8'h00;
        step();
        dm_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_data = 64'hFFFF_0000_FFFF_0000;
        #1;
        check("rw_if_resp", if_resp_valid, 1'b0);
        check("rw_dm_resp", dm_resp_valid, 1'b0);
        check("rw_dm_data", dm_resp_data, 64'h0);
        check("rw_busy", busy, 1'b0);
        check("rw_mem_valid", mem_req_valid, 1'b0);
        check("rw_mem_addr", mem_req_addr, 16'h0);
        check("rw_mem_wdata", mem_req_wdata, 64'h0);
        step();
        mem_resp_valid = 1'b0;
        check("rw_still_idle", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
